// File: rtl/pipelined_dup_csa_checker.sv
// Pipelined adder s = a + b + c_in built from two independent carry-select chains.
// The output stage checks input parity, chain agreement and predicted sum parity.
module pipelined_dup_csa_checker #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     pa,
  input  logic                     pb,
  input  logic                     c_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         s,
  output logic                     c_out,
  output logic                     err_now,
  output logic                     err_sticky,
  output logic [CNT_W-1:0]         err_count,
  input  logic                     clr_err,
  input  logic                     inj_en,
  input  logic [$clog2(WIDTH)-1:0] inj_bit
);

  localparam int unsigned SW = WIDTH / NUM_STAGES;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] sum_p;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] cvec_d;
    logic [WIDTH-1:0] inj;
    logic             cy_p;
    logic             cy_d;
    logic             par_err;
    logic             ppar;
  } stage_t;

  typedef enum logic {StOk, StFault} err_state_e;

  // Carry-select over one slice: blocks of 2,2,4,4,6,6,... each precomputing both carry
  // cases. Returns {carry_out, per-bit carry-in vector, sum}.
  function automatic logic [2*SW:0] csa_slice(input logic [SW-1:0] p, input logic [SW-1:0] g,
                                                input logic cin);
    logic [SW-1:0] sum;
    logic [SW-1:0] cv;
    logic          c_blk;
    logic          c0;
    logic          c1;
    int            pos;
    int            bsz;
    sum   = '0;
    cv    = '0;
    c_blk = cin;
    pos   = 0;
    for (int blk = 0; blk < int'(SW); blk++) begin
      if (pos < int'(SW)) begin
        bsz = 2 * (blk / 2 + 1);
        c0  = 1'b0;
        c1  = 1'b1;
        for (int j = 0; j < int'(SW); j++) begin
          if (j >= pos && j < pos + bsz) begin
            sum[j] = c_blk ? (p[j] ^ c1) : (p[j] ^ c0);
            cv[j]  = c_blk ? c1 : c0;
            c0     = g[j] | (p[j] & c0);
            c1     = g[j] | (p[j] & c1);
          end
        end
        c_blk = c_blk ? c1 : c0;
        pos   = pos + bsz;
      end
    end
    return {c_blk, cv, sum};
  endfunction

  stage_t     cap;
  stage_t     prev [NUM_STAGES];
  stage_t     st_d [NUM_STAGES];
  stage_t     st_q [NUM_STAGES];
  stage_t     last;
  logic [2*SW:0] res_p;
  logic [2*SW:0] res_d;
  logic       advance;
  logic       dup;
  logic       pred;
  logic       deliver_fault;
  err_state_e state_q;
  err_state_e state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Injection is captured as a mask and applied when the owning slice is summed.
  always_comb begin
    cap         = '0;
    cap.valid   = in_valid;
    cap.p       = a ^ b;
    cap.g       = a & b;
    cap.inj     = inj_en ? ({{(WIDTH-1){1'b0}}, 1'b1} << inj_bit) : '0;
    cap.cy_p    = c_in;
    cap.cy_d    = c_in;
    cap.par_err = (pa != ^a) | (pb != ^b);
    cap.ppar    = pa ^ pb;
  end

  always_comb begin
    prev[0] = cap;
    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      prev[k] = st_q[k-1];
    end
  end

  always_comb begin
    res_p = '0;
    res_d = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      res_p = csa_slice(prev[k].p[k*SW +: SW], prev[k].g[k*SW +: SW], prev[k].cy_p);
      res_d = csa_slice(prev[k].p[k*SW +: SW], prev[k].g[k*SW +: SW], prev[k].cy_d);
      st_d[k]                     = prev[k];
      st_d[k].sum_p[k*SW +: SW]   = res_p[SW-1:0];
      st_d[k].sum_d[k*SW +: SW]   = res_d[SW-1:0] ^ prev[k].inj[k*SW +: SW];
      st_d[k].cvec_d[k*SW +: SW]  = res_d[2*SW-1:SW];
      st_d[k].cy_p                = res_p[2*SW];
      st_d[k].cy_d                = res_d[2*SW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        st_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign last      = st_q[NUM_STAGES-1];
  assign out_valid = last.valid;
  assign s         = last.sum_p;
  assign c_out     = last.cy_p;
  assign in_ready  = ~out_valid | out_ready;
  assign advance   = in_ready;

  assign dup     = {last.cy_p, last.sum_p} != {last.cy_d, last.sum_d};
  // Sum parity equals operand parity xor carry-in parity when nothing is broken.
  assign pred    = (^last.sum_p) != (last.ppar ^ (^last.cvec_d));
  assign err_now = out_valid & (last.par_err | dup | pred);

  assign deliver_fault = out_valid & out_ready & err_now;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOk:    if (deliver_fault) state_d = StFault;
      StFault: if (clr_err && !deliver_fault) state_d = StOk;
      default: state_d = StOk;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_err) begin
      cnt_d = deliver_fault ? CNT_W'(1) : '0;
    end else if (deliver_fault && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOk;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_sticky = (state_q == StFault);
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_pipelined_dup_csa_checker.sv
// Directed bench for pipelined_dup_csa_checker: 64/2 main instance plus 32/4 and 16/1
// instances for latency and reset behaviour.
module tb_pipelined_dup_csa_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, clr_err, inj_en, c_in;
  logic [63:0] a, b;
  logic        pa, pb;
  logic [5:0]  inj_bit;
  logic        in_ready, out_valid, c_out, err_now, err_sticky;
  logic [63:0] s;
  logic [7:0]  err_count;

  logic [31:0] a32, b32, s32;
  logic        pa32, pb32, in_ready32, out_valid32, c_out32, err_now32, err_sticky32;
  logic [7:0]  err_count32;
  logic [4:0]  inj_bit32;
  logic [15:0] a16, b16, s16;
  logic        pa16, pb16, in_ready16, out_valid16, c_out16, err_now16, err_sticky16;
  logic [7:0]  err_count16;
  logic [3:0]  inj_bit16;

  int checks = 0;
  int errors = 0;

  assign pa32 = ^a32;
  assign pb32 = ^b32;
  assign pa16 = ^a16;
  assign pb16 = ^b16;
  assign inj_bit32 = 5'd0;
  assign inj_bit16 = 4'd0;

  always #5 clk = ~clk;

  pipelined_dup_csa_checker #(.WIDTH(64), .NUM_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .pa(pa), .pb(pb), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .c_out(c_out), .err_now(err_now), .err_sticky(err_sticky), .err_count(err_count),
    .clr_err(clr_err), .inj_en(inj_en), .inj_bit(inj_bit)
  );

  pipelined_dup_csa_checker #(.WIDTH(32), .NUM_STAGES(4), .CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32), .a(a32), .b(b32),
    .pa(pa32), .pb(pb32), .c_in(c_in), .out_valid(out_valid32), .out_ready(out_ready),
    .s(s32), .c_out(c_out32), .err_now(err_now32), .err_sticky(err_sticky32),
    .err_count(err_count32), .clr_err(clr_err), .inj_en(inj_en), .inj_bit(inj_bit32)
  );

  pipelined_dup_csa_checker #(.WIDTH(16), .NUM_STAGES(1), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .a(a16), .b(b16),
    .pa(pa16), .pb(pb16), .c_in(c_in), .out_valid(out_valid16), .out_ready(out_ready),
    .s(s16), .c_out(c_out16), .err_now(err_now16), .err_sticky(err_sticky16),
    .err_count(err_count16), .clr_err(clr_err), .inj_en(inj_en), .inj_bit(inj_bit16)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        bad;
    logic [63:0] es;
    logic        ec;
    logic        ee;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One isolated operation on the main instance; returns at delivery edge + 1.
  task automatic do_op(input logic [63:0] ta, input logic [63:0] tb, input logic tc,
                       input logic bad, input logic ti, input logic [5:0] tib,
                       output logic [63:0] rs, output logic rc, output logic re,
                       output int lat);
    a = ta; b = tb; c_in = tc; pa = (^ta) ^ bad; pb = ^tb;
    inj_en = ti; inj_bit = tib; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; inj_en = 1'b0;
    lat = 1; rs = '0; rc = 1'b0; re = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        rs = s; rc = c_out; re = err_now;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] rs;
    logic        rc, re;
    int          lat;
    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic [64:0] expq [$];
    logic [64:0] held;
    logic        stalled_prev;
    int          sent, got, del, l32, l16;
    logic        any;

    vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vt[1] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vt[3] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vt[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    vt[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0};
    vt[6] = '{64'h00FF, 64'h0001, 1'b1, 1'b1, 64'h0101, 1'b0, 1'b1};
    vt[7] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) begin
      va[i] = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
      vb[i] = {va[i][31:0], va[i][63:32]} ^ 64'(i * 3);
    end

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_err = 1'b0; inj_en = 1'b0;
    c_in = 1'b0; a = '0; b = '0; pa = 1'b0; pb = 1'b0; inj_bit = '0;
    a32 = '0; b32 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_s", {c_out, s}, 0);
    chk("rst_err", {err_now, err_sticky, err_count}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Table of isolated operations.
    for (int i = 0; i < 8; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].cin, vt[i].bad, 1'b0, 6'd0, rs, rc, re, lat);
      chk($sformatf("v%0d_s", i), rs, vt[i].es);
      chk($sformatf("v%0d_cout", i), rc, vt[i].ec);
      chk($sformatf("v%0d_err", i), re, vt[i].ee);
      chk($sformatf("v%0d_lat", i), lat, 2);
    end
    chk("table_errcount", err_count, 1);
    clear_errors();
    chk("table_clr", {err_sticky, err_count}, 0);

    // Back-to-back stream with a 3-cycle output stall.
    sent = 0; got = 0; stalled_prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid = (sent < 8);
      a = va[sent % 8]; b = vb[sent % 8]; c_in = sent[0];
      pa = ^a; pb = ^b;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", in_ready, 0);
        if (stalled_prev) chk("stall_hold", {c_out, s}, held);
        held = {c_out, s};
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("stream_extra", 1, 0);
        else chk("stream_sum", {c_out, s}, expq.pop_front());
        chk("stream_err", err_now, 0);
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back({1'b0, a} + {1'b0, b} + 65'(c_in));
        sent++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_count", got, 8);
    chk("stream_left", expq.size(), 0);

    // Wrong input parity.
    do_op(64'd3, 64'd5, 1'b0, 1'b1, 1'b0, 6'd0, rs, rc, re, lat);
    chk("par_s", rs, 64'd8);
    chk("par_err_now", re, 1);
    chk("par_sticky", err_sticky, 1);
    chk("par_count", err_count, 1);
    clear_errors();

    // Duplicate-chain injection, then a clean op, then clear.
    do_op(64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 6'd17, rs, rc, re, lat);
    chk("inj_s", rs, 64'd0);
    chk("inj_err_now", re, 1);
    chk("inj_sticky", err_sticky, 1);
    do_op(64'd1, 64'd2, 1'b0, 1'b0, 1'b0, 6'd0, rs, rc, re, lat);
    chk("clean_s", rs, 64'd3);
    chk("clean_err_now", re, 0);
    chk("clean_sticky", err_sticky, 1);
    chk("clean_count", err_count, 1);
    clear_errors();
    chk("inj_clr", {err_sticky, err_count}, 0);

    // Counter saturation.
    a = 64'd3; b = 64'd5; c_in = 1'b0; pa = 1'b1; pb = 1'b0;
    sent = 0; del = 0; in_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && del < 260; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready && err_now) del++;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      in_valid = (sent < 260);
    end
    in_valid = 1'b0;
    chk("sat_deliveries", del, 260);
    chk("sat_count", err_count, 8'd255);
    chk("sat_sticky", err_sticky, 1);

    // Clear coinciding with a faulty delivery.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        any = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("clrsame_seen", any, 1);
    chk("clrsame_err_now", err_now, 1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clrsame_count", err_count, 1);
    chk("clrsame_sticky", err_sticky, 1);
    clear_errors();

    // Latency of the 32/4 and 16/1 instances.
    repeat (6) @(posedge clk);
    #1;
    a = '0; b = '0; pa = 1'b0; pb = 1'b0; c_in = 1'b0;
    a32 = 32'hFFFF_FFFF; b32 = 32'h1; a16 = 16'h8000; b16 = 16'h7FFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l32 = 0; l16 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid32 && l32 == 0) begin
        l32 = i + 1;
        chk("w32_sum", {c_out32, s32}, 33'h1_0000_0000);
        chk("w32_err", err_now32, 0);
      end
      if (out_valid16 && l16 == 0) begin
        l16 = i + 1;
        chk("w16_sum", {c_out16, s16}, 17'h0_FFFF);
        chk("w16_err", err_now16, 0);
      end
      @(posedge clk); #1;
    end
    chk("w32_latency", l32, 4);
    chk("w16_latency", l16, 1);

    // Reset with two operations in flight in every instance.
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {out_valid, out_valid32, out_valid16}, 0);
    chk("midrst_s", {c_out, s}, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid || out_valid32 || out_valid16) any = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst_no_result", any, 0);
    chk("midrst_err", {err_sticky, err_sticky32, err_sticky16, err_count, err_count32,
                       err_count16}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
